// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider with burst/continuous modes, clean stop and
// glitch-free live reconfiguration through a single-entry pending slot.
module clkdiv_ctrl #(
    parameter int unsigned WIDTH        = 10,
    parameter int unsigned DEFAULT_HALF = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_half,
    input  logic [7:0]       cfg_burst,
    input  logic             start,
    input  logic             stop,
    output logic             div_out,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BURST_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_WAIT = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   half_act, half_nxt;
    logic [BURST_W-1:0] burst_act, burst_nxt;
    logic [BURST_W-1:0] burst_left, left_nxt;
    logic [WIDTH-1:0]   pend_half, pend_half_nxt;
    logic [BURST_W-1:0] pend_burst, pend_burst_nxt;
    logic               pend_flag, pend_flag_nxt;
    logic               div_nxt, tick_nxt, done_nxt;

    logic               accept;
    logic               wrap;
    logic               end_run;
    logic [WIDTH-1:0]   half_in;

    assign cfg_ready = ~pend_flag;
    assign busy      = (state != IDLE);
    assign accept    = cfg_valid & ~pend_flag;
    // A zero half-period is meaningless; treat it as the fastest rate.
    assign half_in   = (cfg_half == '0) ? WIDTH'(1) : cfg_half;
    // Compare with >= so a counter can never run past a shortened period.
    assign wrap      = (cnt >= (half_act - WIDTH'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counter, burst accounting and config slot handling
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        div_nxt        = div_out;
        tick_nxt       = 1'b0;
        done_nxt       = 1'b0;
        half_nxt       = half_act;
        burst_nxt      = burst_act;
        left_nxt       = burst_left;
        pend_half_nxt  = pend_half;
        pend_burst_nxt = pend_burst;
        pend_flag_nxt  = pend_flag;
        end_run        = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                div_nxt = 1'b0;
                if (accept) begin
                    half_nxt  = half_in;
                    burst_nxt = cfg_burst;
                end
                if (start) begin
                    state_nxt = RUN;
                    left_nxt  = accept ? cfg_burst : burst_act;
                end
            end
            RUN: begin
                if (stop) begin
                    // Low phase, or high phase ending right now: stop at once.
                    if (!div_out || wrap) begin
                        end_run = 1'b1;
                    end else begin
                        state_nxt = STOP_WAIT;
                    end
                end else if (wrap) begin
                    if (!div_out) begin
                        tick_nxt = 1'b1;
                        if ((burst_act != '0) && (burst_left != '0)) begin
                            left_nxt = burst_left - BURST_W'(1);
                        end
                    end else if ((burst_act != '0) && (burst_left == '0)) begin
                        end_run = 1'b1;
                    end
                end
            end
            STOP_WAIT: begin
                // Only the falling toggle can occur here.
                if (wrap) begin
                    end_run = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state != IDLE) begin
            if (end_run) begin
                state_nxt     = IDLE;
                cnt_nxt       = '0;
                div_nxt       = 1'b0;
                tick_nxt      = 1'b0;
                done_nxt      = 1'b1;
                pend_flag_nxt = 1'b0;
                // A config arriving on the exit edge is newer than any pending one.
                if (accept) begin
                    half_nxt  = half_in;
                    burst_nxt = cfg_burst;
                end else if (pend_flag) begin
                    half_nxt  = pend_half;
                    burst_nxt = pend_burst;
                end
            end else begin
                cnt_nxt = wrap ? '0 : (cnt + WIDTH'(1));
                if (wrap) begin
                    div_nxt = ~div_out;
                    if (pend_flag) begin
                        half_nxt      = pend_half;
                        burst_nxt     = pend_burst;
                        pend_flag_nxt = 1'b0;
                    end
                end
                if (accept) begin
                    pend_half_nxt  = half_in;
                    pend_burst_nxt = cfg_burst;
                    pend_flag_nxt  = 1'b1;
                end
            end
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            div_out    <= 1'b0;
            tick       <= 1'b0;
            done       <= 1'b0;
            half_act   <= WIDTH'(DEFAULT_HALF);
            burst_act  <= '0;
            burst_left <= '0;
            pend_half  <= '0;
            pend_burst <= '0;
            pend_flag  <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            div_out    <= div_nxt;
            tick       <= tick_nxt;
            done       <= done_nxt;
            half_act   <= half_nxt;
            burst_act  <= burst_nxt;
            burst_left <= left_nxt;
            pend_half  <= pend_half_nxt;
            pend_burst <= pend_burst_nxt;
            pend_flag  <= pend_flag_nxt;
        end
    end

endmodule
